// File: rtl/stdp_ctrl.sv
// stdp_ctrl -- pair-based spike-timing-dependent plasticity controller.
//
// Pairs each presynaptic spike with the nearest postsynaptic spike (and vice
// versa) inside a window of WIN cycles. Then it applies a weight step that
// halves for every extra cycle of separation. The step is added when pre
// leads post (potentiation) and subtracted when post leads pre (depression).
// The result saturates to [0,255].
//
// Ports
//   clk           : single clock, rising edge
//   rst_n         : asynchronous active-low reset
//   ena           : enable; low freezes FSM, timer, weight and outputs
//   pre_spike     : presynaptic spike, sampled each rising edge
//   post_spike    : postsynaptic spike, sampled each rising edge
//   weight        : current synaptic weight (registered, unsigned)
//   update_w_flag : one-cycle pulse in the cycle a new weight first appears
//   time_diff     : dt of the most recently applied pair
//   ltp           : direction of the most recently applied pair (1 = potentiation)
//   busy          : high whenever the FSM is not IDLE
//   state_dbg     : raw FSM state for observation (0 IDLE, 1 PRE_WAIT,
//                   2 POST_WAIT, 3 UPDATE)
module stdp_ctrl #(
   parameter logic [7:0] W_INIT = 8'd128,
   parameter logic [7:0] A_MAX  = 8'd16,
   parameter logic [3:0] WIN    = 4'd15
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic       pre_spike,
   input  logic       post_spike,
   output logic [7:0] weight,
   output logic       update_w_flag,
   output logic [3:0] time_diff,
   output logic       ltp,
   output logic       busy,
   output logic [1:0] state_dbg
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRE_WAIT  = 2'd1,
      POST_WAIT = 2'd2,
      UPDATE    = 2'd3
   } state_t;

   state_t     state, state_nx;
   logic [3:0] timer, timer_nx;
   logic [3:0] pend_dt, pend_dt_nx;   // dt of the pair waiting in UPDATE
   logic       pend_ltp, pend_ltp_nx; // direction of the pair waiting in UPDATE
   logic       apply;                 // high while in UPDATE: commit on this edge

   logic [3:0] shamt;
   logic [7:0] dw;
   logic [8:0] w_up;
   logic [8:0] w_dn;
   logic [7:0] weight_nx;

   // ---------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------
   always_comb begin
      state_nx    = state;
      timer_nx    = timer;
      pend_dt_nx  = pend_dt;
      pend_ltp_nx = pend_ltp;
      apply       = 1'b0;
      case (state)
         IDLE: begin
            timer_nx = 4'd0;
            // Coincident pre and post give dt=0, which carries no timing
            // information, so the pair is dropped.
            if (pre_spike && !post_spike) begin
               state_nx = PRE_WAIT;
               timer_nx = 4'd1;
            end else if (post_spike && !pre_spike) begin
               state_nx = POST_WAIT;
               timer_nx = 4'd1;
            end
         end
         PRE_WAIT: begin
            // A partner spike wins over a repeated pre and over the timeout.
            if (post_spike) begin
               pend_dt_nx  = timer;
               pend_ltp_nx = 1'b1;
               timer_nx    = 4'd0;
               state_nx    = UPDATE;
            end else if (pre_spike) begin
               timer_nx = 4'd1;            // nearest-neighbour: newest pre counts
            end else if (timer == WIN) begin
               timer_nx = 4'd0;
               state_nx = IDLE;
            end else begin
               timer_nx = timer + 4'd1;
            end
         end
         POST_WAIT: begin
            if (pre_spike) begin
               pend_dt_nx  = timer;
               pend_ltp_nx = 1'b0;
               timer_nx    = 4'd0;
               state_nx    = UPDATE;
            end else if (post_spike) begin
               timer_nx = 4'd1;
            end else if (timer == WIN) begin
               timer_nx = 4'd0;
               state_nx = IDLE;
            end else begin
               timer_nx = timer + 4'd1;
            end
         end
         UPDATE: begin
            apply    = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // Weight arithmetic: dw = A_MAX >> (dt-1). pend_dt is at least 1 here.
   // A shift of 8 or more naturally yields 0.
   // ---------------------------------------------------------------
   always_comb begin
      shamt = pend_dt - 4'd1;
      dw    = A_MAX >> shamt;
      w_up  = {1'b0, weight} + {1'b0, dw};
      w_dn  = {1'b0, weight} - {1'b0, dw};
      if (pend_ltp) begin
         weight_nx = w_up[8] ? 8'hFF : w_up[7:0];
      end else begin
         weight_nx = w_dn[8] ? 8'h00 : w_dn[7:0];   // borrow means underflow
      end
   end

   // ---------------------------------------------------------------
   // State and output registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         timer         <= 4'd0;
         pend_dt       <= 4'd0;
         pend_ltp      <= 1'b0;
         weight        <= W_INIT;
         update_w_flag <= 1'b0;
         time_diff     <= 4'd0;
         ltp           <= 1'b0;
      end else if (ena) begin
         state         <= state_nx;
         timer         <= timer_nx;
         pend_dt       <= pend_dt_nx;
         pend_ltp      <= pend_ltp_nx;
         update_w_flag <= apply;
         if (apply) begin
            weight    <= weight_nx;
            time_diff <= pend_dt;
            ltp       <= pend_ltp;
         end
      end
   end

   assign busy      = (state != IDLE);
   assign state_dbg = state;

endmodule

// File: doc/stdp_ctrl.md
STDP_CTRL -- requirements
Module: stdp_ctrl

Interface
REQ-001 Parameter W_INIT, default 8'd128: weight value loaded at reset.
REQ-002 Parameter A_MAX, default 8'd16: weight step for a pair whose spike times differ by 1 cycle.
REQ-003 Parameter WIN, default 4'd15: pairing window in cycles, legal range 1..15.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 ena  input  1  enable; when low, the FSM, timer, weight and outputs hold their values.
REQ-007 pre_spike  input  1  presynaptic LIF spike, sampled each rising edge.
REQ-008 post_spike  input  1  postsynaptic LIF spike, sampled each rising edge.
REQ-009 weight  output  8  current synaptic weight, unsigned, registered.
REQ-010 update_w_flag  output  1  one-cycle registered pulse, high in the cycle the new weight is first visible.
REQ-011 time_diff  output  4  dt of the most recent applied pair, registered.
REQ-012 ltp  output  1  direction of the most recent applied pair: 1 = potentiation, 0 = depression.
REQ-013 busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, PRE_WAIT, POST_WAIT and UPDATE.
REQ-015 IDLE, pre only: go to PRE_WAIT with timer=1.
REQ-016 IDLE, post only: go to POST_WAIT with timer=1.
REQ-017 IDLE, pre and post in the same cycle: stay in IDLE, no update (dt=0 is discarded).
REQ-018 PRE_WAIT, post sampled: latch dt=timer and ltp=1, then go to UPDATE; a pre in the same cycle is ignored.
REQ-019 PRE_WAIT, pre only: restart timer=1 and stay in PRE_WAIT (nearest-neighbour pairing).
REQ-020 POST_WAIT mirrors PRE_WAIT with pre and post swapped; the pair latches ltp=0.
REQ-021 In either WAIT state with no partner spike, timer SHALL increment by 1 per enabled cycle.
REQ-022 In either WAIT state with no partner spike and timer==WIN, the FSM SHALL return to IDLE, leave weight unchanged and raise no flag.
REQ-023 UPDATE lasts exactly one enabled cycle and then returns to IDLE; spikes sampled during UPDATE are ignored.
REQ-024 Step size: dw = A_MAX >> (dt-1), computed at 8-bit width; a shift of 8 or more gives dw=0.
REQ-025 Leaving UPDATE: weight <= weight+dw when ltp=1, or weight-dw when ltp=0, saturated to [0,255] with no wrap-around.
REQ-026 Leaving UPDATE: update_w_flag=1 and time_diff=dt for that one cycle; update_w_flag is 0 in every other cycle.
REQ-027 A computed dw of 0 SHALL still pulse update_w_flag, with weight unchanged.
REQ-028 Latency: a partner spike sampled at edge k gives the new weight and update_w_flag=1 after edge k+1.
REQ-029 ena low during any state SHALL freeze the state, the timer and a pending pulse; sequencing resumes unchanged when ena returns high.

Reset
REQ-030 While rst_n=0: state=IDLE, timer=0, weight=W_INIT, update_w_flag=0, time_diff=0, ltp=0, busy=0.
REQ-031 Reset asserted mid-wait or mid-UPDATE SHALL abandon the pending pair with no weight change.
REQ-032 The first spike after rst_n deasserts SHALL be treated as the first spike from IDLE.

Verification
REQ-033 pre at edge 0, post at edge 3 -> dt=3, ltp=1; after edge 4: weight=128+4=132, update_w_flag=1 for one cycle.
REQ-034 post at edge 0, pre at edge 1 -> dt=1, ltp=0; weight=128-16=112.
REQ-035 Weight preloaded to 250, then 5 pairs with pre leading post by 1 cycle -> weight saturates at 255 and holds.
REQ-036 pre alone, no post for WIN=15 cycles -> busy drops after edge 15, no flag, weight unchanged; pre and post in the same cycle from IDLE -> no update.
REQ-037 pre at edge 0, pre at edge 2, post at edge 3 -> dt=1 (timer restarted), weight=144.
REQ-038 Reset asserted while in PRE_WAIT, then ena toggled low for 3 cycles in POST_WAIT -> reset: weight=W_INIT, state=IDLE; ena-low: timer frozen, dt unaffected by the stall.
